// File: rtl/reg_write_arbiter.sv
// Purpose: round-robin write arbiter/sequencer, sole writer of an NREG x W register bank.
// Latency: request seen at edge N -> gnt/reg_en/reg_data flopped high for cycle N..N+1 -> register loads at edge N+1.
// Backpressure: a requester holds req/addr/wdata until its gnt pulse; dropping req before then withdraws the write.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-low reset
//   req[NREQ]       level write request per requester
//   addr[NREQ*AW]   target register, requester i at [i*AW +: AW]
//   wdata[NREQ*W]   write data, requester i at [i*W +: W]
//   lock[NREQ]      burst-hold request (only acted on when RWA_LOCK_EN is defined)
//   gnt[NREQ]       one-hot grant pulse, flopped
//   reg_en[NREG]    one-hot register enable, flopped
//   reg_data[W]     shared register write data, flopped
//   busy            combinational: any req pending or an enable in flight
//
// Optional feature macro: RWA_LOCK_EN (burst ownership via lock).
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int W    = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*W-1:0]  wdata,
  input  logic [NREQ-1:0]    lock,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    reg_en,
  output logic [W-1:0]       reg_data,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREG-1:0] reg_en_q, reg_en_d;
  logic [W-1:0]    reg_data_q, reg_data_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0] elig;
  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic            hold_own;

`ifdef RWA_LOCK_EN
  logic            own_vld_q, own_vld_d;
  logic [PW-1:0]   own_idx_q, own_idx_d;

  // Owner keeps the bank only while both its req and lock stay high.
  assign hold_own = own_vld_q & req[own_idx_q] & lock[own_idx_q];

  // While owning, the owner is the sole candidate and is deliberately not
  // masked by its own grant, giving back-to-back writes.
  always_comb begin
    elig = req & ~gnt_q;
    if (hold_own) begin
      elig             = '0;
      elig[own_idx_q]  = 1'b1;
    end
  end

  always_comb begin
    own_vld_d = 1'b0;
    own_idx_d = own_idx_q;
    if (win_vld && lock[win_idx]) begin
      own_vld_d = 1'b1;
      own_idx_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_vld_q <= 1'b0;
      own_idx_q <= '0;
    end else begin
      own_vld_q <= own_vld_d;
      own_idx_q <= own_idx_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign hold_own    = 1'b0;
  // Masking the current grantee stops a still-high req (it has not yet
  // seen its gnt) from being accepted a second time.
  assign elig        = req & ~gnt_q;
`endif

  // Round-robin search: first eligible requester at or above ptr, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    reg_en_d   = '0;
    reg_data_d = reg_data_q;
    ptr_d      = ptr_q;
    if (win_vld) begin
      gnt_d[win_idx]                          = 1'b1;
      reg_data_d                              = wdata[int'(win_idx)*W +: W];
      reg_en_d[addr[int'(win_idx)*AW +: AW]]  = 1'b1;
      // Pointer freezes during a locked burst so round-robin resumes
      // just past the owner once the burst ends.
      if (!hold_own) begin
        ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q      <= '0;
      reg_en_q   <= '0;
      reg_data_q <= '0;
      ptr_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      reg_en_q   <= reg_en_d;
      reg_data_q <= reg_data_d;
      ptr_q      <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign reg_en   = reg_en_q;
  assign reg_data = reg_data_q;
  assign busy     = (|req) | (|reg_en_q);

endmodule
